// File: rtl/conv_pool_pkg.sv
// Shared helpers for the convolve-and-pool engine: result width, pooling-mode
// encoding and the signed/unsigned max compare.
package conv_pool_pkg;

  typedef enum logic {
    POOL_WINDOW  = 1'b0,
    POOL_RUNNING = 1'b1
  } pool_mode_e;

  function automatic int unsigned acc_width(input int unsigned data_w, input int unsigned taps);
    return 2 * data_w + int'($clog2(taps));
  endfunction

  // Strict a > b on the low w bits; flipping the sign bit turns a signed
  // compare into an unsigned one.
  function automatic logic max_greater(input logic [63:0] a, input logic [63:0] b,
                                       input int unsigned w, input logic sgn);
    logic [63:0] mask;
    logic [63:0] top;
    logic [63:0] am;
    logic [63:0] bm;
    mask = (64'd1 << w) - 64'd1;
    top  = 64'd1 << (w - 1);
    am   = a & mask;
    bm   = b & mask;
    if (sgn) begin
      am = am ^ top;
      bm = bm ^ top;
    end
    return am > bm;
  endfunction

endpackage

// File: rtl/conv_pool_engine_if.sv
// Sample/weight loader and result bus of conv_pool_engine.
interface conv_pool_engine_if
  import conv_pool_pkg::*;
#(
  parameter  int unsigned DATA_W = 6,
  parameter  int unsigned TAPS   = 4,
  localparam int unsigned ACC_W  = acc_width(DATA_W, TAPS)
);
  logic              clear;
  pool_mode_e        pool_mode;
  logic              w_valid;
  logic [DATA_W-1:0] w_data;
  logic              x_valid;
  logic [DATA_W-1:0] x_data;
  logic              x_ready;
  logic              conv_valid;
  logic [ACC_W-1:0]  conv_data;
  logic              out_valid;
  logic [ACC_W-1:0]  out_data;
  logic              weights_ready;

  modport master (
    output clear, pool_mode, w_valid, w_data, x_valid, x_data,
    input  x_ready, conv_valid, conv_data, out_valid, out_data, weights_ready
  );

  modport slave (
    input  clear, pool_mode, w_valid, w_data, x_valid, x_data,
    output x_ready, conv_valid, conv_data, out_valid, out_data, weights_ready
  );
endinterface

// File: rtl/conv_dot_pipe.sv
// Two-stage dot product: registered per-tap products, then a registered
// sign/zero-extended sum with a matching valid pipe.
module conv_dot_pipe
  import conv_pool_pkg::*;
#(
  parameter  int unsigned DATA_W = 6,
  parameter  int unsigned TAPS   = 4,
  parameter  int unsigned SIGNED = 0,
  localparam int unsigned ACC_W  = acc_width(DATA_W, TAPS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_flush,
  input  logic                         i_valid,
  input  logic [TAPS-1:0][DATA_W-1:0]  i_x,
  input  logic [TAPS-1:0][DATA_W-1:0]  i_w,
  output logic                         o_valid,
  output logic [ACC_W-1:0]             o_data
);
  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam int unsigned EXT_W  = ACC_W - PROD_W;

  logic [TAPS-1:0][PROD_W-1:0] w_prod;
  logic [TAPS-1:0][PROD_W-1:0] r_prod;
  logic [PROD_W-1:0]           w_xe;
  logic [PROD_W-1:0]           w_we;
  logic [ACC_W-1:0]            w_sum;
  logic [ACC_W-1:0]            r_sum;
  logic                        r_prod_valid;
  logic                        r_sum_valid;

  // Operands widened to the product width first, so the low PROD_W bits of the
  // product are correct for both signed and unsigned data.
  always_comb begin
    w_prod = '0;
    w_xe   = '0;
    w_we   = '0;
    for (int unsigned t = 0; t < TAPS; t++) begin
      w_xe      = {{DATA_W{(SIGNED != 0) && i_x[t][DATA_W-1]}}, i_x[t]};
      w_we      = {{DATA_W{(SIGNED != 0) && i_w[t][DATA_W-1]}}, i_w[t]};
      w_prod[t] = w_xe * w_we;
    end
  end

  always_comb begin
    w_sum = '0;
    for (int unsigned t = 0; t < TAPS; t++) begin
      w_sum = w_sum + {{EXT_W{(SIGNED != 0) && r_prod[t][PROD_W-1]}}, r_prod[t]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prod       <= '0;
      r_prod_valid <= 1'b0;
      r_sum        <= '0;
      r_sum_valid  <= 1'b0;
    end else begin
      r_prod_valid <= i_valid && !i_flush;
      r_sum_valid  <= r_prod_valid && !i_flush;
      if (i_valid) r_prod <= w_prod;
      if (r_prod_valid) r_sum <= w_sum;
    end
  end

  assign o_valid = r_sum_valid;
  assign o_data  = r_sum;
endmodule

// File: rtl/conv_pool_engine.sv
// Sliding-window convolver with windowed or running max pooling of the
// dot-product results.
module conv_pool_engine
  import conv_pool_pkg::*;
#(
  parameter  int unsigned DATA_W   = 6,
  parameter  int unsigned TAPS     = 4,
  parameter  int unsigned POOL_LEN = 4,
  parameter  int unsigned SIGNED   = 0,
  localparam int unsigned ACC_W    = acc_width(DATA_W, TAPS)
) (
  input logic               clk,
  input logic               rst,
  conv_pool_engine_if.slave eng
);
  localparam int unsigned FILL_W = $clog2(TAPS + 1);
  localparam int unsigned PCNT_W = (POOL_LEN > 1) ? $clog2(POOL_LEN) : 1;
  localparam logic [ACC_W-1:0] MAX_INIT = (SIGNED != 0) ? {1'b1, {(ACC_W-1){1'b0}}} : '0;

  logic [TAPS-1:0][DATA_W-1:0] r_w;
  logic [TAPS-1:0][DATA_W-1:0] r_x;
  logic [FILL_W-1:0]           r_w_cnt;
  logic [FILL_W-1:0]           r_fill;
  logic                        r_launch;
  logic                        w_accept;
  logic                        w_conv_valid;
  logic [ACC_W-1:0]            w_conv_data;

  pool_mode_e                  r_mode_q;
  logic [PCNT_W-1:0]           r_pcnt;
  logic [PCNT_W-1:0]           w_pcnt;
  logic [ACC_W-1:0]            r_max;
  logic [ACC_W-1:0]            w_new_max;
  logic                        r_seen;
  logic                        w_first;
  logic                        r_out_valid;
  logic [ACC_W-1:0]            r_out_data;

  assign eng.x_ready       = !eng.w_valid;
  assign w_accept          = eng.x_valid && !eng.w_valid;
  assign eng.weights_ready = (r_w_cnt == FILL_W'(TAPS));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_w     <= '0;
      r_w_cnt <= '0;
    end else if (eng.w_valid) begin
      r_w <= {eng.w_data, r_w[TAPS-1:1]};
      if (r_w_cnt != FILL_W'(TAPS)) r_w_cnt <= r_w_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x      <= '0;
      r_fill   <= '0;
      r_launch <= 1'b0;
    end else if (eng.clear) begin
      r_x      <= '0;
      r_fill   <= '0;
      r_launch <= 1'b0;
    end else begin
      r_launch <= w_accept && (r_fill >= FILL_W'(TAPS - 1));
      if (w_accept) begin
        r_x <= {eng.x_data, r_x[TAPS-1:1]};
        if (r_fill != FILL_W'(TAPS)) r_fill <= r_fill + 1'b1;
      end
    end
  end

  conv_dot_pipe #(
    .DATA_W (DATA_W),
    .TAPS   (TAPS),
    .SIGNED (SIGNED)
  ) u_dot (
    .clk     (clk),
    .rst     (rst),
    .i_flush (eng.clear),
    .i_valid (r_launch),
    .i_x     (r_x),
    .i_w     (r_w),
    .o_valid (w_conv_valid),
    .o_data  (w_conv_data)
  );

  // A mode switch restarts the pool count for the result arriving that cycle.
  always_comb begin
    w_pcnt    = (eng.pool_mode != r_mode_q) ? '0 : r_pcnt;
    w_first   = (eng.pool_mode == POOL_RUNNING) ? !r_seen : (w_pcnt == '0);
    w_new_max = (w_first || max_greater(64'(w_conv_data), 64'(r_max), ACC_W, SIGNED != 0))
                ? w_conv_data : r_max;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode_q    <= POOL_WINDOW;
      r_pcnt      <= '0;
      r_max       <= MAX_INIT;
      r_seen      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (eng.clear) begin
      r_mode_q    <= eng.pool_mode;
      r_pcnt      <= '0;
      r_max       <= MAX_INIT;
      r_seen      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_mode_q <= eng.pool_mode;
      r_pcnt   <= w_pcnt;
      if (eng.pool_mode == POOL_WINDOW) begin
        r_out_valid <= 1'b0;
        if (w_conv_valid) begin
          r_max <= w_new_max;
          if (w_pcnt == PCNT_W'(POOL_LEN - 1)) begin
            r_pcnt      <= '0;
            r_out_valid <= 1'b1;
            r_out_data  <= w_new_max;
          end else begin
            r_pcnt <= w_pcnt + 1'b1;
          end
        end
      end else begin
        r_pcnt      <= '0;
        r_out_valid <= r_seen || w_conv_valid;
        if (w_conv_valid) begin
          r_max      <= w_new_max;
          r_seen     <= 1'b1;
          r_out_data <= w_new_max;
        end
      end
    end
  end

  assign eng.conv_valid = w_conv_valid;
  assign eng.conv_data  = w_conv_data;
  assign eng.out_valid  = r_out_valid;
  assign eng.out_data   = r_out_data;
endmodule
